// File: rtl/riscv_core_mul_seq.sv
// Iterative radix-2 shift-add multiplier for the M-extension execute path.
// Consumes operand magnitudes plus raw signs and returns MUL/MULH/MULHSU/MULHU/MULW results.
module riscv_core_mul_seq #(
    parameter int unsigned XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_mul_start,
    input  logic            i_mul_kill,
    input  logic [XLEN-1:0] i_mul_multiplicand,
    input  logic [XLEN-1:0] i_mul_multiplier,
    input  logic            i_mul_srcA_sign,
    input  logic            i_mul_srcB_sign,
    input  logic [1:0]      i_mul_control,
    input  logic            i_mul_isword,
    output logic [XLEN-1:0] o_mul_result,
    output logic            o_mul_valid,
    output logic            o_mul_busy
);

    localparam int unsigned HALF = XLEN / 2;
    localparam int unsigned CW   = $clog2(XLEN + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MULT = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam logic [CW-1:0]     CNT_FULL = CW'(XLEN);
    localparam logic [CW-1:0]     CNT_WORD = CW'(HALF);
    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [XLEN-1:0]   LO_MASK  = {{HALF{1'b0}}, {HALF{1'b1}}};
    localparam logic [2*XLEN-1:0] PROD_ONE = {{(2*XLEN-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic              isword_q, isword_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              valid_q, valid_d;

    logic              neg_in;
    logic [XLEN-1:0]   op_a, op_b;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   fix_result;

    // Word ops always use the rs1^rs2 sign rule, whatever control says.
    always_comb begin
        if (i_mul_isword) begin
            neg_in = i_mul_srcA_sign ^ i_mul_srcB_sign;
        end else begin
            case (i_mul_control)
                2'b10:   neg_in = i_mul_srcA_sign;
                2'b11:   neg_in = 1'b0;
                default: neg_in = i_mul_srcA_sign ^ i_mul_srcB_sign;
            endcase
        end
    end

    assign op_a   = i_mul_isword ? (i_mul_multiplicand & LO_MASK) : i_mul_multiplicand;
    assign op_b   = i_mul_isword ? (i_mul_multiplier & LO_MASK) : i_mul_multiplier;
    assign prod_s = neg_q ? (~acc_q + PROD_ONE) : acc_q;

    always_comb begin
        if (isword_q) begin
            fix_result = {{HALF{prod_s[HALF-1]}}, prod_s[HALF-1:0]};
        end else if (ctrl_q == 2'b00) begin
            fix_result = prod_s[XLEN-1:0];
        end else begin
            fix_result = prod_s[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        ctrl_d   = ctrl_q;
        isword_d = isword_q;
        neg_d    = neg_q;
        result_d = result_q;
        valid_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_mul_start && !i_mul_kill) begin
                    mcand_d  = {{XLEN{1'b0}}, op_a};
                    mplier_d = op_b;
                    ctrl_d   = i_mul_control;
                    isword_d = i_mul_isword;
                    neg_d    = neg_in;
                    acc_d    = '0;
                    cnt_d    = i_mul_isword ? CNT_WORD : CNT_FULL;
                    state_d  = ST_MULT;
                end
            end
            ST_MULT: begin
                if (i_mul_kill) begin
                    state_d = ST_IDLE;
                end else begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!i_mul_kill) begin
                    result_d = fix_result;
                    valid_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            ctrl_q   <= '0;
            isword_q <= 1'b0;
            neg_q    <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            ctrl_q   <= ctrl_d;
            isword_q <= isword_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign o_mul_result = result_q;
    assign o_mul_valid  = valid_q;
    assign o_mul_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_riscv_core_mul_seq.sv
// Self-checking bench for riscv_core_mul_seq: scoreboard of expected results, one task per scenario.
module tb_riscv_core_mul_seq;

    localparam int XLEN = 64;
    localparam int LAT_D = 65;
    localparam int LAT_W = 33;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            kill = 1'b0;
    logic [XLEN-1:0] mcand = '0;
    logic [XLEN-1:0] mplier = '0;
    logic            sign_a = 1'b0;
    logic            sign_b = 1'b0;
    logic [1:0]      ctrl = 2'b00;
    logic            isword = 1'b0;
    logic [XLEN-1:0] result;
    logic            valid;
    logic            busy;

    int checks = 0;
    int passes = 0;
    logic [XLEN-1:0] sb[$];
    logic [XLEN-1:0] last_result = '0;

    riscv_core_mul_seq #(.XLEN(XLEN)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_mul_start        (start),
        .i_mul_kill         (kill),
        .i_mul_multiplicand (mcand),
        .i_mul_multiplier   (mplier),
        .i_mul_srcA_sign    (sign_a),
        .i_mul_srcB_sign    (sign_b),
        .i_mul_control      (ctrl),
        .i_mul_isword       (isword),
        .o_mul_result       (result),
        .o_mul_valid        (valid),
        .o_mul_busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    // Conditioning-stage model: magnitude of rs, upper half garbage in word mode.
    function automatic logic [63:0] mag(input logic [63:0] rs, input logic signed_op,
                                        input logic word);
        logic [31:0] lo;
        if (word) begin
            lo = rs[31:0];
            if (signed_op && lo[31]) lo = -lo;
            return {$urandom(), lo};
        end
        return (signed_op && rs[63]) ? -rs : rs;
    endfunction

    // Architectural reference from raw register values.
    function automatic logic [63:0] ref_res(input logic [63:0] rs1, input logic [63:0] rs2,
                                            input logic [1:0] c, input logic word);
        logic [127:0] a, b, p;
        if (word) begin
            a = {{96{rs1[31]}}, rs1[31:0]};
            b = {{96{rs2[31]}}, rs2[31:0]};
            p = a * b;
            return {{32{p[31]}}, p[31:0]};
        end
        a = (c == 2'b11) ? {64'd0, rs1} : {{64{rs1[63]}}, rs1};
        b = (c[1]) ? {64'd0, rs2} : {{64{rs2[63]}}, rs2};
        p = a * b;
        return (c == 2'b00) ? p[63:0] : p[127:64];
    endfunction

    task automatic set_ops(input logic [63:0] rs1, input logic [63:0] rs2,
                           input logic [1:0] c, input logic word);
        mcand  = mag(rs1, word || (c != 2'b11), word);
        mplier = mag(rs2, word || (c[1] == 1'b0), word);
        sign_a = word ? rs1[31] : rs1[63];
        sign_b = word ? rs2[31] : rs2[63];
        ctrl   = c;
        isword = word;
    endtask

    // Called at posedge+1; returns just after the accept edge, inputs scrambled.
    task automatic start_op(input logic [63:0] rs1, input logic [63:0] rs2,
                            input logic [1:0] c, input logic word, input logic [63:0] exp);
        set_ops(rs1, rs2, c, word);
        start = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        sb.push_back(exp);
        set_ops(rand64(), rand64(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    endtask

    task automatic run_to_valid(output int lat, output logic [63:0] res);
        lat = -1;
        res = 'x;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk) #1;
            if (valid === 1'b1) begin
                lat = i;
                res = result;
                break;
            end
        end
    endtask

    task automatic count_valids(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk) #1;
            if (valid === 1'b1) n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (result !== 64'd0) $display("FAIL reset_result got %h want 0", result); else passes++;
        checks++; if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
        rst = 1'b0;
        @(posedge clk) #1;
    endtask

    task automatic test_op(input string name, input logic [63:0] rs1, input logic [63:0] rs2,
                           input logic [1:0] c, input logic word, input logic [63:0] exp);
        int lat;
        logic [63:0] res, want;
        int want_lat;
        want_lat = word ? LAT_W : LAT_D;
        start_op(rs1, rs2, c, word, exp);
        checks++; if (busy !== 1'b1) $display("FAIL %s_busy got %b want 1", name, busy); else passes++;
        run_to_valid(lat, res);
        want = sb.pop_front();
        checks++;
        if (lat != want_lat) $display("FAIL %s_latency got %0d want %0d", name, lat, want_lat);
        else passes++;
        checks++;
        if (res !== want) $display("FAIL %s_result got %h want %h", name, res, want);
        else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL %s_busy_end got %b want 0", name, busy); else passes++;
        last_result = want;
        @(posedge clk) #1;
        checks++; if (valid !== 1'b0) $display("FAIL %s_valid_width got %b want 0", name, valid); else passes++;
    endtask

    task automatic test_random();
        logic [63:0] a, b;
        logic [1:0] c;
        logic w;
        for (int i = 0; i < 6; i++) begin
            a = rand64();
            b = rand64();
            if (i == 0) a = 64'h8000_0000_0000_0000;
            c = 2'(i % 4);
            w = (i >= 4);
            test_op("random", a, b, c, w, ref_res(a, b, c, w));
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [63:0] res, want;
        start_op(64'd5, 64'd6, 2'b00, 1'b0, 64'd30);
        run_to_valid(lat, res);
        want = sb.pop_front();
        checks++; if (res !== want) $display("FAIL b2b_a_result got %h want %h", res, want); else passes++;
        start_op(64'd3, 64'd3, 2'b00, 1'b0, 64'd9);
        run_to_valid(lat, res);
        want = sb.pop_front();
        checks++;
        if (lat != LAT_D) $display("FAIL b2b_b_latency got %0d want %0d", lat, LAT_D); else passes++;
        checks++; if (res !== want) $display("FAIL b2b_b_result got %h want %h", res, want); else passes++;
        last_result = want;
    endtask

    task automatic test_busy_ignore();
        int lat, n;
        logic [63:0] res, want;
        start_op(64'd11, 64'd13, 2'b00, 1'b0, 64'd143);
        for (int i = 0; i < 3; i++) begin
            set_ops(64'd2, 64'd2, 2'b00, 1'b0);
            start = 1'b1;
            @(posedge clk) #1;
            start = 1'b0;
        end
        run_to_valid(lat, res);
        want = sb.pop_front();
        checks++;
        if (lat != LAT_D - 3) $display("FAIL busy_ign_latency got %0d want %0d", lat, LAT_D - 3);
        else passes++;
        checks++; if (res !== want) $display("FAIL busy_ign_result got %h want %h", res, want); else passes++;
        last_result = want;
        count_valids(80, n);
        checks++; if (n != 0) $display("FAIL busy_ign_extra got %0d valids want 0", n); else passes++;
    endtask

    task automatic test_kill(input string name, input int kill_cycle);
        int n;
        start_op(64'd1234, 64'd5678, 2'b00, 1'b0, 64'd7006652);
        repeat (kill_cycle - 1) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk) #1;
        kill = 1'b0;
        void'(sb.pop_front());
        checks++; if (busy !== 1'b0) $display("FAIL %s_busy got %b want 0", name, busy); else passes++;
        checks++; if (valid !== 1'b0) $display("FAIL %s_valid got %b want 0", name, valid); else passes++;
        checks++;
        if (result !== last_result) $display("FAIL %s_result got %h want %h", name, result, last_result);
        else passes++;
        count_valids(80, n);
        checks++; if (n != 0) $display("FAIL %s_late_valid got %0d want 0", name, n); else passes++;
    endtask

    task automatic test_kill_start_idle();
        set_ops(64'd3, 64'd4, 2'b00, 1'b0);
        start = 1'b1;
        kill = 1'b1;
        @(posedge clk) #1;
        start = 1'b0;
        kill = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL kill_start_busy got %b want 0", busy); else passes++;
    endtask

    task automatic test_reset_mid();
        int n;
        start_op(64'd99, 64'd77, 2'b00, 1'b0, 64'd7623);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0;
        void'(sb.pop_front());
        last_result = '0;
        checks++; if (result !== 64'd0) $display("FAIL rst_mid_result got %h want 0", result); else passes++;
        checks++; if (valid !== 1'b0) $display("FAIL rst_mid_valid got %b want 0", valid); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", busy); else passes++;
        count_valids(80, n);
        checks++; if (n != 0) $display("FAIL rst_mid_late_valid got %0d want 0", n); else passes++;
    endtask

    initial begin
        test_reset();
        test_op("mul_7x-3", 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB);
        test_op("mulh_min", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b01, 1'b0,
                64'h4000_0000_0000_0000);
        test_op("mulhu_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFE);
        test_op("mulhsu_m1x2", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 2'b10, 1'b0,
                64'hFFFF_FFFF_FFFF_FFFF);
        test_op("mulw", 64'hDEAD_BEEF_7FFF_FFFF, 64'h1234_5678_0000_0002, 2'b00, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFE);
        test_op("mulw_ctrl01", 64'h0000_0000_FFFF_FFFD, 64'hABCD_0000_0000_0005, 2'b01, 1'b1,
                64'hFFFF_FFFF_FFFF_FFF1);
        test_op("mul_zero", 64'd0, 64'hFFFF_0000_1234_5678, 2'b00, 1'b0, 64'd0);
        test_random();
        test_back_to_back();
        test_busy_ignore();
        test_kill("kill_mult", 20);
        test_kill("kill_fix", LAT_D);
        test_kill_start_idle();
        test_reset_mid();
        test_op("after_reset", 64'd6, 64'd7, 2'b11, 1'b0, 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/riscv_core_mul_seq.md
# riscv_core_mul_seq

Iterative radix-2 shift-add multiplier for the M-extension execute path. It sits directly downstream of the multiplier input-conditioning stage and consumes that stage's operand magnitudes. It forms the unsigned 2·XLEN-bit product, restores the sign, and selects the lower or upper XLEN bits, or the sign-extended 32-bit word. The result is returned over a start/busy/valid handshake to the execute-stage mux.

## Interface
- XLEN, 64, datapath width; must be even.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_mul_start  in  1  request; accepted only when o_mul_busy=0.
- i_mul_kill  in  1  pipeline flush; aborts an operation in flight.
- i_mul_multiplicand  in  XLEN  magnitude of rs1 from the conditioning stage.
- i_mul_multiplier  in  XLEN  magnitude of rs2 from the conditioning stage.
- i_mul_srcA_sign  in  1  raw rs1 sign: bit XLEN-1, or bit XLEN/2-1 when isword.
- i_mul_srcB_sign  in  1  raw rs2 sign, same bit rule as srcA.
- i_mul_control  in  2  00 MUL/MULW, 01 MULH, 10 MULHSU, 11 MULHU.
- i_mul_isword  in  1  1 = MULW (32-bit operation).
- o_mul_result  out  XLEN  final rd value; holds until the next valid.
- o_mul_valid  out  1  one-cycle result strobe.
- o_mul_busy  out  1  operation in progress.

## Operation
- States: IDLE, MULT, FIX.
- IDLE, start=1, kill=0:
  - latch multiplicand, multiplier, control, isword;
  - compute and latch neg:
    - MUL / MULH: srcA_sign^srcB_sign;
    - MULHSU: srcA_sign;
    - MULHU: 0;
    - isword: srcA_sign^srcB_sign (control treated as MULW regardless of value);
  - clear the product accumulator;
  - load iteration counter N = XLEN, or XLEN/2 when isword;
  - go to MULT.
- MULT: one multiplier bit per cycle.
  - If the current bit is 1, add the multiplicand into the accumulator (carry kept); then shift.
  - Counter decrements; at zero go to FIX.
  - In word mode, operand bits above XLEN/2-1 are treated as 0.
- FIX: P = unsigned product, 2·XLEN bits; S = neg ? (~P + 1) : P, mod 2^(2·XLEN).
  - Result select:
    - MUL: S[XLEN-1:0];
    - MULH/MULHSU/MULHU: S[2·XLEN-1:XLEN];
    - MULW: sign-extend S[XLEN/2-1:0] to XLEN.
  - Register into o_mul_result, pulse o_mul_valid, go to IDLE.
- Most-negative operand: its magnitude arrives as 2^(XLEN-1) and is treated as unsigned. This is correct, and no special case exists.
- A zero operand still runs all N iterations; there is no early termination.
- Start while busy is ignored; no queueing.

## Timing
- Reset: state IDLE, o_mul_result=0, o_mul_valid=0, o_mul_busy=0, accumulator and counter 0.
- Start sampled at edge E0. o_mul_busy is high from E0 until edge E(N+1).
- At E(N+1): o_mul_result is updated, o_mul_valid=1 for exactly one cycle, and o_mul_busy=0.
- Latency start→valid: 65 cycles for doubleword, 33 cycles for word (XLEN=64).
- Back-to-back: start may be asserted during the valid cycle and is accepted. The next valid follows N+1 cycles later.
- Kill in MULT or FIX: IDLE at the next edge, busy=0, no valid pulse, o_mul_result unchanged.
- Kill and start together in IDLE: start is ignored.
- Reset has priority over kill and start. Reset mid-operation returns to IDLE with no valid pulse.
- Inputs are sampled only at the accept edge; later changes have no effect.

## Test plan
- MUL 7×(−3): magnitudes 7 and 3, signs 0/1 → valid after 65 cycles, result 0xFFFF_FFFF_FFFF_FFEB.
- MULH, both operands 0x8000_0000_0000_0000 (magnitudes 2^63, signs 1/1) → 0x4000_0000_0000_0000.
- MULHU 0xFFFF_FFFF_FFFF_FFFF×0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE. MULHSU with rs1=−1 (magnitude 1, signA=1), rs2=2 → 0xFFFF_FFFF_FFFF_FFFF.
- MULW 0x7FFF_FFFF×2, upper operand bits garbage → valid after 33 cycles, result 0xFFFF_FFFF_FFFF_FFFE.
- Start asserted during the valid cycle of op A (5×6), op B is 3×3 → 30, then 9 exactly 65 cycles later. Start pulses while busy → ignored.
- Kill at cycle 20 of MUL → no valid, busy falls next cycle, result unchanged. Reset at cycle 10 → all outputs 0.
